rt_job_port: RTL and testbench

Per-RT-core endpoint of the patch dispatcher's RT job interface. It accepts one-cycle `job_dispatch` pulses carrying a thread context (thread ID, pixel ID, PC, SP) and buffers them in a small FIFO that the core drains through a valid/ready handshake. It collects the core's completion and yield events and returns them to the dispatcher as registered one-cycle `task_done` / `context_switch` pulses. It tracks which thread IDs are resident on this core and flags protocol violations.

---
 rtl/rt_dispatch_pkg.sv | 31 +++
 rtl/rt_job_port_if.sv | 56 +++++
 rtl/rt_job_fifo.sv | 54 +++++
 rtl/rt_job_port.sv | 132 +++++++++++++
 tb/tb_rt_job_port.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rt_dispatch_pkg.sv
// Shared types and default sizing for the patch dispatcher and its per-core RT job ports.
// Thread IDs travel in a fixed-width field so one struct serves every thread-count configuration.
package rt_dispatch_pkg;

  localparam int RT_NUM_THREAD = 32;
  localparam int RT_BIT_THREAD = $clog2(RT_NUM_THREAD);
  localparam int RT_FIFO_DEPTH = 4;

  // Widest thread ID any configuration may use; narrower IDs are zero-extended into it.
  localparam int RT_TID_MAX_W  = 16;

  typedef logic [RT_TID_MAX_W-1:0] rt_tid_t;

  typedef struct packed {
    rt_tid_t     thread_id;
    logic [31:0] pixel_id;
    logic [31:0] pc;
    logic [31:0] sp;
  } rt_job_t;

  typedef struct packed {
    rt_tid_t     thread_id;
    logic [31:0] pc;
    logic [31:0] sp;
  } rt_evt_t;

  function automatic rt_tid_t widen_tid(input logic [RT_TID_MAX_W-1:0] tid);
    return tid;
  endfunction

endpackage

// File: rtl/rt_job_port_if.sv
// Bundle of dispatcher-side, core-side and status signals of one RT job port.
// The slave modport is the port itself; the master modport is its surroundings.
interface rt_job_port_if import rt_dispatch_pkg::*; #(
  parameter int BIT_THREAD = RT_BIT_THREAD
);

  logic                  job_dispatch;
  logic [BIT_THREAD-1:0] thread_id_in;
  logic [31:0]           pixel_id_in;
  logic [31:0]           pc_in;
  logic [31:0]           sp_in;
  logic                  busy;

  logic                  task_done;
  logic                  context_switch;
  logic [BIT_THREAD-1:0] thread_id_out;
  logic [31:0]           pc_out;
  logic [31:0]           sp_out;

  logic                  job_valid;
  logic                  job_ready;
  logic [BIT_THREAD-1:0] job_thread_id;
  logic [31:0]           job_pixel_id;
  logic [31:0]           job_pc;
  logic [31:0]           job_sp;

  logic                  core_done;
  logic                  core_yield;
  logic [BIT_THREAD-1:0] core_thread_id;
  logic [31:0]           core_pc;
  logic [31:0]           core_sp;

  logic [BIT_THREAD:0]   resident_cnt;
  logic                  err;

  modport slave (
    input  job_dispatch, thread_id_in, pixel_id_in, pc_in, sp_in,
    output busy,
    output task_done, context_switch, thread_id_out, pc_out, sp_out,
    output job_valid, job_thread_id, job_pixel_id, job_pc, job_sp,
    input  job_ready,
    input  core_done, core_yield, core_thread_id, core_pc, core_sp,
    output resident_cnt, err
  );

  modport master (
    output job_dispatch, thread_id_in, pixel_id_in, pc_in, sp_in,
    input  busy,
    input  task_done, context_switch, thread_id_out, pc_out, sp_out,
    input  job_valid, job_thread_id, job_pixel_id, job_pc, job_sp,
    output job_ready,
    output core_done, core_yield, core_thread_id, core_pc, core_sp,
    input  resident_cnt, err
  );

endinterface

// File: rtl/rt_job_fifo.sv
// Show-ahead job FIFO: the head entry is visible whenever the FIFO is non-empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module rt_job_fifo import rt_dispatch_pkg::*; #(
  parameter int DEPTH = RT_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  rt_job_t        push_data,
  input  logic           pop,
  output rt_job_t        head,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  rt_job_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset; the head is masked while empty so stale entries never show.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/rt_job_port.sv
// Per-RT-core job port: buffers dispatched thread contexts, returns core done/yield events
// as registered pulses, tracks resident threads and latches protocol errors.
module rt_job_port import rt_dispatch_pkg::*; #(
  parameter int NUM_THREAD = RT_NUM_THREAD,
  parameter int BIT_THREAD = $clog2(NUM_THREAD),
  parameter int FIFO_DEPTH = RT_FIFO_DEPTH
) (
  input logic          clk,
  input logic          rst,
  rt_job_port_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NUM_THREAD-1:0] ONE_HOT0 = NUM_THREAD'(1);

  rt_job_t          push_job;
  rt_job_t          head_job;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;
  logic             push;

  assign pop  = !fifo_empty && bus.job_ready;
  assign push = bus.job_dispatch && (!fifo_full || pop);

  assign push_job = '{thread_id: widen_tid(rt_tid_t'(bus.thread_id_in)),
                      pixel_id:  bus.pixel_id_in,
                      pc:        bus.pc_in,
                      sp:        bus.sp_in};

  rt_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_job),
    .pop       (pop),
    .head      (head_job),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.busy          = fifo_full;
  assign bus.job_valid     = !fifo_empty;
  assign bus.job_thread_id = head_job.thread_id[BIT_THREAD-1:0];
  assign bus.job_pixel_id  = head_job.pixel_id;
  assign bus.job_pc        = head_job.pc;
  assign bus.job_sp        = head_job.sp;

  logic [NUM_THREAD-1:0] mask_q;
  logic [NUM_THREAD-1:0] mask_kept;
  logic [NUM_THREAD-1:0] mask_next;
  logic [NUM_THREAD-1:0] clr_vec;
  logic [NUM_THREAD-1:0] set_vec;
  logic [BIT_THREAD:0]   cnt_next;
  logic [BIT_THREAD:0]   resident_cnt_q;
  logic                  evt;

  assign evt = bus.core_done || bus.core_yield;

  // An event clears its thread before a same-cycle dispatch sets it, so the redispatch wins.
  always_comb begin
    clr_vec   = evt  ? (ONE_HOT0 << bus.core_thread_id) : '0;
    set_vec   = push ? (ONE_HOT0 << bus.thread_id_in)   : '0;
    mask_kept = mask_q & ~clr_vec;
    mask_next = mask_kept | set_vec;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NUM_THREAD; i++) begin
      cnt_next = cnt_next + {{BIT_THREAD{1'b0}}, mask_next[i]};
    end
  end

  logic drop_err;
  logic dup_err;
  logic orphan_err;
  logic both_err;
  logic err_q;

  always_comb begin
    drop_err   = bus.job_dispatch && fifo_full && !pop;
    dup_err    = bus.job_dispatch && mask_kept[bus.thread_id_in];
    orphan_err = evt && !mask_q[bus.core_thread_id];
    both_err   = bus.core_done && bus.core_yield;
  end

  rt_evt_t evt_q;
  logic    task_done_q;
  logic    context_switch_q;

  // A simultaneous done and yield is reported as done only.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q           <= '0;
      resident_cnt_q   <= '0;
      err_q            <= 1'b0;
      task_done_q      <= 1'b0;
      context_switch_q <= 1'b0;
      evt_q            <= '0;
    end else begin
      mask_q           <= mask_next;
      resident_cnt_q   <= cnt_next;
      err_q            <= err_q || drop_err || dup_err || orphan_err || both_err;
      task_done_q      <= bus.core_done;
      context_switch_q <= bus.core_yield && !bus.core_done;
      if (evt) begin
        evt_q <= '{thread_id: widen_tid(rt_tid_t'(bus.core_thread_id)),
                   pc:        bus.core_pc,
                   sp:        bus.core_sp};
      end
    end
  end

  assign bus.task_done      = task_done_q;
  assign bus.context_switch = context_switch_q;
  assign bus.thread_id_out  = evt_q.thread_id[BIT_THREAD-1:0];
  assign bus.pc_out         = evt_q.pc;
  assign bus.sp_out         = evt_q.sp;
  assign bus.resident_cnt   = resident_cnt_q;
  assign bus.err            = err_q;

  logic unused_bits;
  assign unused_bits = ^{head_job.thread_id[RT_TID_MAX_W-1:BIT_THREAD],
                         evt_q.thread_id[RT_TID_MAX_W-1:BIT_THREAD],
                         fifo_count};

endmodule

// File: tb/tb_rt_job_port.sv
// Bench for rt_job_port: a queue/array model of the job port checked every cycle,
// plus hand-computed expectations at key points of a directed scenario.
module tb_rt_job_port;
  import rt_dispatch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rt_job_port_if #(.BIT_THREAD(5)) bus ();

  rt_job_port #(
    .NUM_THREAD (32),
    .BIT_THREAD (5),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tid;
    logic [31:0] pix;
    logic [31:0] pc;
    logic [31:0] sp;
  } job_m_t;

  job_m_t      q[$];
  bit          res[32];
  bit          m_err;
  bit          m_td;
  bit          m_cs;
  logic [4:0]  m_tid;
  logic [31:0] m_pc;
  logic [31:0] m_sp;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int resident_total();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(res[i]);
    return n;
  endfunction

  // Model: jobs are a list, residency is a set of thread IDs, events echo one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        for (int i = 0; i < 32; i++) res[i] = 1'b0;
        m_err = 0; m_td = 0; m_cs = 0; m_tid = '0; m_pc = '0; m_sp = '0;
      end else begin
        bit pop_now;
        bit evt_now;
        pop_now = (q.size() > 0) && bus.job_ready;
        evt_now = bus.core_done || bus.core_yield;
        if (evt_now) begin
          if (!res[bus.core_thread_id]) m_err = 1;
          res[bus.core_thread_id] = 1'b0;
          m_tid = bus.core_thread_id;
          m_pc  = bus.core_pc;
          m_sp  = bus.core_sp;
        end
        if (bus.core_done && bus.core_yield) m_err = 1;
        m_td = bus.core_done;
        m_cs = bus.core_yield && !bus.core_done;
        if (pop_now) void'(q.pop_front());
        if (bus.job_dispatch) begin
          if (q.size() < DEPTH) begin
            if (res[bus.thread_id_in]) m_err = 1;
            q.push_back('{bus.thread_id_in, bus.pixel_id_in, bus.pc_in, bus.sp_in});
            res[bus.thread_id_in] = 1'b1;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check_output("model job_valid", bus.job_valid, q.size() > 0);
      check_output("model busy", bus.busy, q.size() == DEPTH);
      if (q.size() > 0) begin
        check_output("model job_thread_id", bus.job_thread_id, q[0].tid);
        check_output("model job_pixel_id", bus.job_pixel_id, q[0].pix);
        check_output("model job_pc", bus.job_pc, q[0].pc);
        check_output("model job_sp", bus.job_sp, q[0].sp);
      end
      check_output("model task_done", bus.task_done, m_td);
      check_output("model context_switch", bus.context_switch, m_cs);
      check_output("model thread_id_out", bus.thread_id_out, m_tid);
      check_output("model pc_out", bus.pc_out, m_pc);
      check_output("model sp_out", bus.sp_out, m_sp);
      check_output("model resident_cnt", bus.resident_cnt, resident_total());
      check_output("model err", bus.err, m_err);
    end
  end

  task automatic apply_stimulus(input logic disp, input logic [4:0] tid, input logic [31:0] pix,
                                input logic [31:0] pc, input logic [31:0] sp, input logic rdy,
                                input logic done, input logic yld, input logic [4:0] ctid,
                                input logic [31:0] cpc, input logic [31:0] csp);
    bus.job_dispatch   = disp;
    bus.thread_id_in   = tid;
    bus.pixel_id_in    = pix;
    bus.pc_in          = pc;
    bus.sp_in          = sp;
    bus.job_ready      = rdy;
    bus.core_done      = done;
    bus.core_yield     = yld;
    bus.core_thread_id = ctid;
    bus.core_pc        = cpc;
    bus.core_sp        = csp;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    apply_stimulus(0, 0, 0, 0, 0, rdy, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.job_dispatch = 1'b1; bus.thread_id_in = 5'd3; bus.pixel_id_in = 32'h1;
    bus.pc_in = 32'h2; bus.sp_in = 32'h3; bus.job_ready = 1'b0;
    bus.core_done = 1'b0; bus.core_yield = 1'b0; bus.core_thread_id = '0;
    bus.core_pc = '0; bus.core_sp = '0;
    repeat (2) @(negedge clk);
    check_output("reset job_valid", bus.job_valid, 0);
    check_output("reset busy", bus.busy, 0);
    check_output("reset task_done", bus.task_done, 0);
    check_output("reset context_switch", bus.context_switch, 0);
    check_output("reset thread_id_out", bus.thread_id_out, 0);
    check_output("reset pc_out", bus.pc_out, 0);
    check_output("reset sp_out", bus.sp_out, 0);
    check_output("reset job_thread_id", bus.job_thread_id, 0);
    check_output("reset job_pixel_id", bus.job_pixel_id, 0);
    check_output("reset job_pc", bus.job_pc, 0);
    check_output("reset job_sp", bus.job_sp, 0);
    check_output("reset resident_cnt", bus.resident_cnt, 0);
    check_output("reset err", bus.err, 0);
    rst = 1'b0;

    apply_stimulus(1, 5, 32'h40, 32'h100, 32'h8000, 0, 0, 0, 0, 0, 0);
    check_output("single job_valid", bus.job_valid, 1);
    check_output("single head tid", bus.job_thread_id, 5);
    check_output("single head pixel", bus.job_pixel_id, 32'h40);
    check_output("single head pc", bus.job_pc, 32'h100);
    check_output("single head sp", bus.job_sp, 32'h8000);
    check_output("single resident_cnt", bus.resident_cnt, 1);

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1A4, 32'h7FF0);
    check_output("yield context_switch", bus.context_switch, 1);
    check_output("yield task_done", bus.task_done, 0);
    check_output("yield thread_id_out", bus.thread_id_out, 5);
    check_output("yield pc_out", bus.pc_out, 32'h1A4);
    check_output("yield sp_out", bus.sp_out, 32'h7FF0);
    check_output("yield resident_cnt", bus.resident_cnt, 0);

    idle(1);
    check_output("drain single job_valid", bus.job_valid, 0);
    check_output("yield pulse one cycle", bus.context_switch, 0);

    for (int i = 0; i < 4; i++)
      apply_stimulus(1, 5'(i), 32'h100 + i, 32'h200 + i, 32'h300 + i, 0, 0, 0, 0, 0, 0);
    check_output("fill busy", bus.busy, 1);
    check_output("fill resident_cnt", bus.resident_cnt, 4);
    check_output("fill head tid", bus.job_thread_id, 0);

    apply_stimulus(1, 6, 32'h600, 32'h601, 32'h602, 1, 0, 0, 0, 0, 0);
    check_output("full+pop busy", bus.busy, 1);
    check_output("full+pop err", bus.err, 0);
    check_output("full+pop head tid", bus.job_thread_id, 1);
    check_output("full+pop resident_cnt", bus.resident_cnt, 5);

    apply_stimulus(1, 7, 32'h700, 32'h701, 32'h702, 0, 0, 0, 0, 0, 0);
    check_output("overflow err", bus.err, 1);
    check_output("overflow resident_cnt", bus.resident_cnt, 5);
    check_output("overflow head tid", bus.job_thread_id, 1);

    idle(1);
    check_output("drain1 head tid", bus.job_thread_id, 2);
    check_output("drain1 busy falls", bus.busy, 0);
    idle(1);
    check_output("drain2 head tid", bus.job_thread_id, 3);
    idle(1);
    check_output("drain3 head tid", bus.job_thread_id, 6);
    check_output("drain3 head pixel", bus.job_pixel_id, 32'h600);
    idle(1);
    check_output("drain4 job_valid", bus.job_valid, 0);

    apply_stimulus(1, 8, 32'h800, 32'h801, 32'h802, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h55, 32'h66);
    check_output("midreset task_done", bus.task_done, 0);
    check_output("midreset job_valid", bus.job_valid, 0);
    check_output("midreset err", bus.err, 0);
    check_output("midreset resident_cnt", bus.resident_cnt, 0);
    rst = 1'b0;

    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 9, 32'hAA, 32'hBB);
    check_output("orphan task_done", bus.task_done, 1);
    check_output("orphan thread_id_out", bus.thread_id_out, 9);
    check_output("orphan err", bus.err, 1);
    idle(0);
    check_output("hold task_done", bus.task_done, 0);
    check_output("hold pc_out", bus.pc_out, 32'hAA);

    rst = 1'b1;
    idle(0);
    rst = 1'b0;
    apply_stimulus(1, 2, 32'h20, 32'h21, 32'h22, 1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1, 2, 32'h11, 32'h22);
    check_output("both task_done", bus.task_done, 1);
    check_output("both context_switch", bus.context_switch, 0);
    check_output("both resident_cnt", bus.resident_cnt, 0);
    check_output("both err", bus.err, 1);

    rst = 1'b1;
    idle(0);
    rst = 1'b0;
    apply_stimulus(1, 4, 32'h40, 32'h41, 32'h42, 1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 4, 32'h43, 32'h44, 32'h45, 1, 1, 0, 4, 32'h90, 32'h91);
    check_output("redispatch task_done", bus.task_done, 1);
    check_output("redispatch resident_cnt", bus.resident_cnt, 1);
    check_output("redispatch err", bus.err, 0);
    apply_stimulus(1, 4, 32'h46, 32'h47, 32'h48, 0, 0, 0, 0, 0, 0);
    check_output("duplicate err", bus.err, 1);
    check_output("duplicate resident_cnt", bus.resident_cnt, 1);

    for (int i = 0; i < 24; i++) begin
      apply_stimulus((i % 3) != 0, 5'(i % 8), 32'h1000 + i, 32'h2000 + i, 32'h3000 + i,
                     (i % 2) == 1, (i % 4) == 1, (i % 4) == 3, 5'((i + 5) % 8),
                     32'h4000 + i, 32'h5000 + i);
    end
    repeat (6) idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
